// File: rtl/mfm_encoder.sv
// MFM write-path serialiser: bytes in, raw clock/data cells out, MSB first.
// Handles A1 sync marks (missing clock, 0x4489) and gap-byte fill on underrun.
module mfm_encoder #(
  parameter int         CELL_DIV = 1,
  parameter logic [7:0] GAP_BYTE = 8'h4E
) (
  input  logic        clk_5,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  in_data,
  input  logic        in_sync,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        raw_mfm,
  output logic [15:0] mfm_word,
  output logic        byte_strobe,
  output logic        underrun,
  output logic        busy
);

  localparam int CW = (CELL_DIV > 1) ? $clog2(CELL_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CELL_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cell_cnt;
  logic [3:0]    bit_cnt;
  logic [14:0]   sh;
  logic          prev_d;
  logic          hold_valid, hold_sync;
  logic [7:0]    hold_data;

  logic          load, pop, gap, stop, shift;
  logic          cell_end, word_end;
  logic [7:0]    src_byte;
  logic          src_sync;
  logic [15:0]   enc;
  logic          hold_nv;

  function automatic logic [15:0] mfm_enc(
    input logic [7:0] d,
    input logic       sync,
    input logic       p
  );
    logic [15:0] w;
    logic        pr;
    w  = '0;
    pr = p;
    for (int i = 7; i >= 0; i--) begin
      w[2*i+1] = ~pr & ~d[i];
      w[2*i]   = d[i];
      pr       = d[i];
    end
    // sync mark drops the clock between the two zero data bits
    if (sync && d == 8'hA1) w[5] = 1'b0;
    return w;
  endfunction

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    pop      = 1'b0;
    gap      = 1'b0;
    stop     = 1'b0;
    shift    = 1'b0;
    cell_end = (cell_cnt == CMAX);
    word_end = cell_end && (bit_cnt == 4'd15);
    src_byte = hold_valid ? hold_data : GAP_BYTE;
    src_sync = hold_valid & hold_sync;
    enc      = mfm_enc(src_byte, src_sync, prev_d);
    unique case (state)
      IDLE: begin
        if (hold_valid && enable) begin
          load = 1'b1;
          pop  = 1'b1;
          nxt  = RUN;
        end
      end
      RUN: begin
        if (word_end) begin
          if (!enable) begin
            stop = 1'b1;
            nxt  = IDLE;
          end else begin
            load = 1'b1;
            pop  = hold_valid;
            gap  = ~hold_valid;
          end
        end else if (cell_end) begin
          shift = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
    hold_nv = hold_valid;
    if (pop) hold_nv = 1'b0;
    else if (in_valid && in_ready) hold_nv = 1'b1;
  end

  always_ff @(posedge clk_5) begin
    if (reset) begin
      state       <= IDLE;
      cell_cnt    <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      prev_d      <= 1'b0;
      raw_mfm     <= 1'b0;
      mfm_word    <= '0;
      byte_strobe <= 1'b0;
      underrun    <= 1'b0;
      busy        <= 1'b0;
      hold_valid  <= 1'b0;
      hold_sync   <= 1'b0;
      hold_data   <= '0;
      in_ready    <= 1'b1;
    end else begin
      state       <= nxt;
      byte_strobe <= load;
      underrun    <= gap;
      busy        <= (nxt == RUN);
      if (load) begin
        sh       <= enc[14:0];
        mfm_word <= enc;
        raw_mfm  <= enc[15];
        prev_d   <= src_byte[0];
        cell_cnt <= '0;
        bit_cnt  <= '0;
      end else if (stop) begin
        raw_mfm  <= 1'b0;
        prev_d   <= 1'b0;
        cell_cnt <= '0;
        bit_cnt  <= '0;
      end else if (shift) begin
        sh       <= {sh[13:0], 1'b0};
        raw_mfm  <= sh[14];
        cell_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else if (state == RUN) begin
        cell_cnt <= cell_cnt + 1'b1;
      end
      hold_valid <= hold_nv;
      in_ready   <= ~hold_nv;
      if (!pop && in_valid && in_ready) begin
        hold_data <= in_data;
        hold_sync <= in_sync;
      end
    end
  end

endmodule

// File: tb/tb_mfm_encoder.sv
// Directed bench for mfm_encoder: word encodings, cell timing,
// underrun fill, sync marks, slow cells and mid-word reset.
module tb_mfm_encoder;

  logic        clk_5 = 1'b0;
  logic        reset;
  logic        enable, in_sync, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, raw_mfm, byte_strobe, underrun, busy;
  logic [15:0] mfm_word;

  logic        en3, sync3, valid3;
  logic [7:0]  data3;
  logic        ready3, raw3, strobe3, under3, busy3;
  logic [15:0] word3;

  int checks = 0;
  int errors = 0;

  always #5 clk_5 = ~clk_5;

  mfm_encoder #(.CELL_DIV(1), .GAP_BYTE(8'h4E)) u1 (
    .clk_5(clk_5), .reset(reset), .enable(enable),
    .in_data(in_data), .in_sync(in_sync), .in_valid(in_valid),
    .in_ready(in_ready), .raw_mfm(raw_mfm), .mfm_word(mfm_word),
    .byte_strobe(byte_strobe), .underrun(underrun), .busy(busy)
  );

  mfm_encoder #(.CELL_DIV(3), .GAP_BYTE(8'h4E)) u3 (
    .clk_5(clk_5), .reset(reset), .enable(en3),
    .in_data(data3), .in_sync(sync3), .in_valid(valid3),
    .in_ready(ready3), .raw_mfm(raw3), .mfm_word(word3),
    .byte_strobe(strobe3), .underrun(under3), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk_5);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic s);
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (in_ready) break;
      tick();
    end
    chk("push_ready", in_ready, 16'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Walks the cells of the word on raw_mfm starting at cell 'start';
  // returns just after the edge that ends the last cell.
  task automatic run_word(input logic [15:0] exp, input int start,
                          input logic exp_un);
    chk("mfm_word", mfm_word, exp);
    chk("busy_run", busy, 16'd1);
    if (start == 0) begin
      chk("strobe_load", byte_strobe, 16'd1);
      chk("underrun_load", underrun, {15'd0, exp_un});
    end
    for (int i = start; i < 16; i++) begin
      chk($sformatf("cell%0d_%h", i, exp), raw_mfm, {15'd0, exp[15-i]});
      if (i > 0) begin
        chk("strobe_mid", byte_strobe, 16'd0);
        chk("underrun_mid", underrun, 16'd0);
      end
      tick();
    end
  endtask

  logic [15:0] w;

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0;
    in_data = '0; in_sync = 1'b0;
    en3 = 1'b0; valid3 = 1'b0; data3 = '0; sync3 = 1'b0;
    tick();
    tick();
    chk("rst_raw", raw_mfm, 16'd0);
    chk("rst_word", mfm_word, 16'h0000);
    chk("rst_strobe", byte_strobe, 16'd0);
    chk("rst_underrun", underrun, 16'd0);
    chk("rst_busy", busy, 16'd0);
    chk("rst_ready", in_ready, 16'd1);
    reset = 1'b0;
    tick();

    // 00 -> AAAA, one-cycle load latency after handshake
    enable = 1'b1;
    push(8'h00, 1'b0);
    chk("t1_ready_full", in_ready, 16'd0);
    chk("t1_not_busy", busy, 16'd0);
    tick();
    enable = 1'b0;
    run_word(16'hAAAA, 0, 1'b0);
    chk("t1_idle_busy", busy, 16'd0);
    chk("t1_idle_raw", raw_mfm, 16'd0);
    chk("t1_word_hold", mfm_word, 16'hAAAA);
    chk("t1_ready", in_ready, 16'd1);

    // FF then 00 back to back
    push(8'hFF, 1'b0);
    tick();
    chk("t2_hold_no_en", busy, 16'd0);
    enable = 1'b1;
    push(8'h00, 1'b0);
    run_word(16'h5555, 1, 1'b0);
    enable = 1'b0;
    run_word(16'h2AAA, 0, 1'b0);
    chk("t2_idle_busy", busy, 16'd0);
    chk("t2_idle_raw", raw_mfm, 16'd0);

    // sync marks
    enable = 1'b1;
    push(8'hA1, 1'b1);
    tick();
    enable = 1'b0;
    run_word(16'h4489, 0, 1'b0);
    enable = 1'b1;
    push(8'hA1, 1'b0);
    tick();
    enable = 1'b0;
    run_word(16'h44A9, 0, 1'b0);
    enable = 1'b1;
    push(8'h00, 1'b1);
    tick();
    enable = 1'b0;
    run_word(16'hAAAA, 0, 1'b0);

    // underrun gap fill
    enable = 1'b1;
    push(8'hFF, 1'b0);
    tick();
    run_word(16'h5555, 0, 1'b0);
    run_word(16'h1254, 0, 1'b1);
    enable = 1'b0;
    run_word(16'h9254, 0, 1'b1);
    chk("t4_idle_busy", busy, 16'd0);
    chk("t4_idle_under", underrun, 16'd0);

    // CELL_DIV=3
    en3 = 1'b1;
    data3 = 8'h00;
    valid3 = 1'b1;
    chk("t5_ready", ready3, 16'd1);
    tick();
    valid3 = 1'b0;
    tick();
    chk("t5_word", word3, 16'hAAAA);
    w = 16'hAAAA;
    for (int c = 0; c < 48; c++) begin
      chk($sformatf("t5_cyc%0d", c), raw3, {15'd0, w[15 - c/3]});
      chk($sformatf("t5_strb%0d", c), strobe3, {15'd0, c == 0});
      tick();
    end
    chk("t5_strobe48", strobe3, 16'd1);
    chk("t5_under", under3, 16'd1);
    chk("t5_gapword", word3, 16'h9254);
    en3 = 1'b0;
    for (int c = 0; c < 48; c++) tick();
    chk("t5_idle_busy", busy3, 16'd0);
    chk("t5_idle_raw", raw3, 16'd0);

    // reset at cell 7 with a byte waiting in the holding reg
    enable = 1'b1;
    push(8'h00, 1'b0);
    tick();
    chk("t6_load", byte_strobe, 16'd1);
    push(8'hFF, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    chk("t6_busy_c7", busy, 16'd1);
    chk("t6_hold_full", in_ready, 16'd0);
    reset = 1'b1;
    tick();
    chk("t6_raw", raw_mfm, 16'd0);
    chk("t6_busy", busy, 16'd0);
    chk("t6_ready", in_ready, 16'd1);
    chk("t6_strobe", byte_strobe, 16'd0);
    chk("t6_word", mfm_word, 16'h0000);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_discard_busy", busy, 16'd0);
    chk("t6_discard_strobe", byte_strobe, 16'd0);
    push(8'h00, 1'b0);
    tick();
    enable = 1'b0;
    run_word(16'hAAAA, 0, 1'b0);
    chk("t6_end_busy", busy, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
